// File: rtl/systolic_matmul_nxn_pkg.sv
// Shared types and sizing helpers for the NxN systolic matrix multiplier.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    OUTPUT
  } state_t;

  // Accumulator width that cannot overflow for N products of two DW-bit
  // operands, in either signed or unsigned interpretation.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_matmul_nxn_pe.sv
// One processing element: forwards a right and b down, accumulates a*b.
module systolic_pe #(
  parameter int DW = 4,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic          clr,
  input  logic          signed_mode,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [AW-1:0] ax, bx, prod;

  // Extending both operands to AW first makes the low AW bits of the product
  // correct for either interpretation, so one multiplier serves both modes.
  assign ax   = signed_mode ? {{(AW-DW){a_in[DW-1]}}, a_in} : {{(AW-DW){1'b0}}, a_in};
  assign bx   = signed_mode ? {{(AW-DW){b_in[DW-1]}}, b_in} : {{(AW-DW){1'b0}}, b_in};
  assign prod = ax * bx;

  // Operand forwarding and accumulation; clr holds the PE at zero between jobs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod;
    end
  end

endmodule

// File: rtl/systolic_matmul_nxn.sv
// NxN output-stationary systolic multiplier: load A, load B, run the skewed
// wavefront through the PE grid, then stream C out row-major.
module systolic_matmul_nxn
  import systolic_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 4,
  parameter int AW = acc_width(N, DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          signed_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int KW = $clog2(3 * N);

  state_t                  state, state_nx;
  logic [IW-1:0]           cnt;
  logic [KW-1:0]           k;
  logic                    mode;
  logic [NN-1:0][DW-1:0]   a_buf, b_buf;
  logic [N-1:0][DW-1:0]    row_inj, col_inj;
  logic [NN-1:0][AW-1:0]   acc;
  logic [N-1:0][N-2:0][DW-1:0] a_link;
  logic [N-2:0][N-1:0][DW-1:0] b_link;
  logic                    beat_in, beat_out, cnt_end, k_end, clr;

  assign beat_in  = in_valid & in_ready;
  assign beat_out = out_valid & out_ready;
  assign cnt_end  = (cnt == IW'(NN - 1));
  assign k_end    = (k == KW'(3 * N - 2));
  assign clr      = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nx = LOAD_A;
      LOAD_A: begin
        in_ready = 1'b1;
        if (beat_in && cnt_end) state_nx = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (beat_in && cnt_end) state_nx = COMPUTE;
      end
      COMPUTE: if (k_end) state_nx = OUTPUT;
      OUTPUT: begin
        out_valid = 1'b1;
        out_last  = cnt_end;
        if (beat_out && cnt_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Element counter (load and output index), compute cycle counter, buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      k     <= '0;
      mode  <= 1'b0;
      a_buf <= '0;
      b_buf <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt  <= '0;
          mode <= signed_mode;
        end
        LOAD_A: if (beat_in) begin
          a_buf[cnt] <= in_data;
          cnt        <= cnt_end ? '0 : cnt + IW'(1);
        end
        LOAD_B: if (beat_in) begin
          b_buf[cnt] <= in_data;
          cnt        <= cnt_end ? '0 : cnt + IW'(1);
          k          <= '0;
        end
        COMPUTE: k <= k + KW'(1);
        OUTPUT: if (beat_out) cnt <= cnt_end ? '0 : cnt + IW'(1);
        default: ;
      endcase
    end
  end

  // Skewed edge injection: row i sees A[i][k-i], column j sees B[k-j][j].
  always_comb begin
    row_inj = '0;
    col_inj = '0;
    if (state == COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < N; s++) begin
          if (k == KW'(s + i)) begin
            row_inj[i] = a_buf[i*N + s];
            col_inj[i] = b_buf[s*N + i];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0] a_i, b_i, a_o, b_o;

      if (gj == 0) begin : g_aedge
        assign a_i = row_inj[gi];
      end else begin : g_ain
        assign a_i = a_link[gi][gj-1];
      end
      if (gi == 0) begin : g_bedge
        assign b_i = col_inj[gj];
      end else begin : g_bin
        assign b_i = b_link[gi-1][gj];
      end

      // Operands leaving the right and bottom edges have no consumer.
      if (gj < N - 1) begin : g_afwd
        assign a_link[gi][gj] = a_o;
      end else begin : g_aend
        logic [DW-1:0] a_unused;
        assign a_unused = a_o;
      end
      if (gi < N - 1) begin : g_bfwd
        assign b_link[gi][gj] = b_o;
      end else begin : g_bend
        logic [DW-1:0] b_unused;
        assign b_unused = b_o;
      end

      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_in        (a_i),
        .b_in        (b_i),
        .clr         (clr),
        .signed_mode (mode),
        .a_out       (a_o),
        .b_out       (b_o),
        .acc         (acc[gi*N + gj])
      );
    end
  end

  // Accumulators are frozen in OUTPUT (the grid has drained to zeros),
  // so the presented element stays stable while the consumer stalls.
  assign out_data = (state == OUTPUT) ? acc[cnt] : '0;

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Scoreboarded random and directed bench; one N=2 and one N=3 instance.
module tb_systolic_matmul_nxn;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start[2], smode[2], iv[2], ordy[2];
  logic [3:0] idat[2];
  logic       ir[2], ov[2], ol[2], by[2];
  logic [8:0] od2;
  logic [9:0] od3;

  systolic_matmul_nxn #(.N(2), .DW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .signed_mode(smode[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od2),
    .out_last(ol[0]), .busy(by[0])
  );

  systolic_matmul_nxn #(.N(3), .DW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .signed_mode(smode[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od3),
    .out_last(ol[1]), .busy(by[1])
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned d;
    bit          last;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  function automatic int unsigned od(input int u);
    return (u == 0) ? 32'(od2) : 32'(od3);
  endfunction

  task automatic check(input string nm, input int unsigned act, input int unsigned req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: plain matrix product, result reduced to the output width.
  function automatic int sx(input int v, input bit sm);
    return (sm && v >= 8) ? v - 16 : v;
  endfunction

  task automatic push_exp(input int u, input int n, input bit sm, input int a[9], input int b[9]);
    int   sum;
    int   aw;
    exp_t e;
    aw = (u == 0) ? 9 : 10;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        sum = 0;
        for (int s = 0; s < n; s++) sum += sx(a[r*n+s], sm) * sx(b[s*n+c], sm);
        e.d    = int'(unsigned'(sum)) & ((1 << aw) - 1);
        e.last = (r == n-1) && (c == n-1);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
  endtask

  // Monitor: every output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (rst_n === 1'b1 && ov[u] === 1'b1 && ordy[u] === 1'b1) begin
        if (((u == 0) ? q0.size() : q1.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out u%0d: got %0d expected no output", u, od(u));
        end else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          check("out_data", od(u), e.d);
          check("out_last", 32'(ol[u]), 32'(e.last));
        end
      end
    end
  end

  task automatic send(input int u, input int v);
    int vv;
    bit got;
    vv      = v;
    got     = 1'b0;
    idat[u] = vv[3:0];
    iv[u]   = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (ir[u]) got = 1'b1;
    end
    if (!got) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    iv[u] = 1'b0;
  endtask

  task automatic run_job(input int u, input int n, input bit sm, input int a[9], input int b[9],
                         input bit gap, input bit stall, input bit pulse, input bit chk_lat,
                         input bit expect_out);
    int          cyc;
    int unsigned hold;
    bit          seen;
    if (expect_out) push_exp(u, n, sm, a, b);
    @(posedge clk); #1;
    smode[u] = sm;
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    smode[u] = ~sm;
    check("ready_after_start", 32'(ir[u]), 1);
    for (int i = 0; i < 2*n*n; i++) begin
      if (pulse && i == n*n) begin
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        check("busy_after_loadb_start", 32'(by[u]), 1);
      end
      if (gap) begin
        iv[u] = 1'b0;
        @(posedge clk); #1;
      end
      send(u, (i < n*n) ? a[i] : b[i - n*n]);
    end
    if (!expect_out) return;
    seen = 1'b0;
    cyc  = 0;
    for (int t = 1; t <= 100 && !seen; t++) begin
      @(negedge clk);
      cyc = t;
      if (ov[u]) seen = 1'b1;
    end
    if (!seen) check("out_valid_timeout", 0, 1);
    if (chk_lat) check("first_out_latency", cyc, 3*n);
    if (pulse) begin
      @(posedge clk); #1;
      start[u] = 1'b1;
      @(posedge clk); #1;
      start[u] = 1'b0;
      check("busy_after_output_start", 32'(by[u]), 1);
    end
    if (stall) begin
      @(posedge clk); #1;
      ordy[u] = 1'b0;
      @(negedge clk);
      hold = od(u);
      for (int t = 0; t < 5; t++) begin
        @(negedge clk);
        check("stall_data_stable", od(u), hold);
        check("stall_valid_held", 32'(ov[u]), 1);
      end
      @(posedge clk); #1;
      ordy[u] = 1'b1;
    end
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (!by[u]) seen = 1'b1;
    end
    check("job_done", 32'(by[u]), 0);
    check("scoreboard_drained", (u == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      check({tag, "_in_ready"},  32'(ir[u]), 0);
      check({tag, "_out_valid"}, 32'(ov[u]), 0);
      check({tag, "_out_data"},  od(u), 0);
      check({tag, "_out_last"},  32'(ol[u]), 0);
      check({tag, "_busy"},      32'(by[u]), 0);
    end
  endtask

  int ta[9], tb[9];

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; smode[u] = 1'b0; iv[u] = 1'b0; ordy[u] = 1'b1; idat[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    // Directed N=2 example, including latency from the last B beat.
    ta = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    tb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    run_job(0, 2, 1'b0, ta, tb, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Extremes: all-ones unsigned, most-negative signed.
    ta = '{15, 15, 15, 15, 0, 0, 0, 0, 0};
    run_job(0, 2, 1'b0, ta, ta, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ta = '{8, 8, 8, 8, 0, 0, 0, 0, 0};
    run_job(0, 2, 1'b1, ta, ta, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // N=3: identity times 1..9, then an all-zero A.
    ta = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    tb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_job(1, 3, 1'b0, ta, tb, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    ta = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_job(1, 3, 1'b0, ta, tb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Input gaps and a mid-output consumer stall.
    ta = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    tb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    run_job(0, 2, 1'b0, ta, tb, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin ta[i] = int'($urandom_range(0, 15)); tb[i] = int'($urandom_range(0, 15)); end
    run_job(1, 3, 1'b1, ta, tb, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in COMPUTE cycle 2 aborts the job with no output.
    ta = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    run_job(0, 2, 1'b0, ta, tb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_job_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_idle_outputs("after_abort");
    tb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    run_job(0, 2, 1'b0, ta, tb, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Stray start pulses during LOAD_B and OUTPUT.
    run_job(0, 2, 1'b0, ta, tb, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Random jobs on both sizes and both modes.
    for (int it = 0; it < 12; it++) begin
      int u;
      u = it % 2;
      for (int i = 0; i < 9; i++) begin ta[i] = int'($urandom_range(0, 15)); tb[i] = int'($urandom_range(0, 15)); end
      run_job(u, u + 2, 1'($urandom_range(0, 1)), ta, tb, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b1);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always ends with a summary.
  initial begin
    #400000;
    bad++;
    $display("FAIL global_timeout: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
